tb_cmd_dispatcher: RTL and testbench

// Hardware command dispatcher for the generic testbench. Accepts one command at a

---
 rtl/tb_cmd_dispatcher_if.sv | 27 ++
 rtl/tb_cmd_dispatcher.sv | 188 ++++++++++++++++++
 tb/tb_tb_cmd_dispatcher.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tb_cmd_dispatcher_if.sv
// Command/response channel between the sequencer and the command dispatcher.
// Commands use valid/ready; responses are single-cycle pulses with no backpressure.
interface tb_cmd_dispatcher_if #(
    parameter int unsigned SET_WIDTH = 32,
    parameter int unsigned IDX_W     = 3,
    parameter int unsigned CNT_W     = 16
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_op;
    logic [IDX_W-1:0]     cmd_idx;
    logic [SET_WIDTH-1:0] cmd_data;
    logic [CNT_W-1:0]     cmd_timeout;
    logic                 rsp_valid;
    logic [1:0]           rsp_status;
    logic [CNT_W-1:0]     rsp_elapsed;

    modport master (
        output cmd_valid, cmd_op, cmd_idx, cmd_data, cmd_timeout,
        input  cmd_ready, rsp_valid, rsp_status, rsp_elapsed
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_idx, cmd_data, cmd_timeout,
        output cmd_ready, rsp_valid, rsp_status, rsp_elapsed
    );
endinterface

// File: rtl/tb_cmd_dispatcher.sv
// Executes one SET / WAIT_EVENT / WAIT_DURATION / NOP command at a time and
// returns exactly one status response per accepted command.
module tb_cmd_dispatcher #(
    parameter int unsigned SET_SIZE  = 5,
    parameter int unsigned SET_WIDTH = 32,
    parameter int unsigned WAIT_SIZE = 5,
    parameter int unsigned IDX_W     = 3,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    tb_cmd_dispatcher_if.slave   cmd,
    input  logic                 abort,
    input  logic [WAIT_SIZE-1:0] wait_signals,
    output logic                 set_en,
    output logic [IDX_W-1:0]     set_idx,
    output logic [SET_WIDTH-1:0] set_value
);
    typedef enum logic [2:0] {S_IDLE, S_SET, S_WAIT_EV, S_WAIT_DUR, S_RESP} state_t;
    typedef enum logic [1:0] {OP_SET, OP_WAIT_EV, OP_WAIT_DUR, OP_NOP} op_t;
    typedef enum logic [1:0] {RS_OK, RS_TIMEOUT, RS_BAD_IDX, RS_ABORTED} status_t;

    localparam int unsigned    PAD_W    = 2 ** IDX_W;
    localparam logic [IDX_W:0] SET_LIM  = (IDX_W + 1)'(SET_SIZE);
    localparam logic [IDX_W:0] WAIT_LIM = (IDX_W + 1)'(WAIT_SIZE);

    state_t               r_state;
    logic                 r_ready;
    logic                 r_set_en;
    logic [IDX_W-1:0]     r_set_idx;
    logic [SET_WIDTH-1:0] r_set_value;
    logic                 r_rsp_valid;
    status_t              r_rsp_status;
    logic [CNT_W-1:0]     r_rsp_elapsed;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     r_limit;
    logic                 r_prev;
    logic [IDX_W-1:0]     r_idx;
    logic [1:0]           r_kind;

    op_t                  w_op;
    logic [PAD_W-1:0]     w_wait_pad;
    logic                 w_cur;
    logic                 w_acc_bit;
    logic                 w_accept;
    logic                 w_idx_bad;
    logic [CNT_W-1:0]     w_dur;
    logic                 w_limit_hit;
    logic                 w_event;
    logic                 w_fin;
    status_t              w_fin_status;
    logic [CNT_W-1:0]     w_fin_elapsed;

    // Zero-padding lets out-of-range indices read 0 without a separate range check.
    assign w_wait_pad  = PAD_W'(wait_signals);
    assign w_cur       = w_wait_pad[r_idx];
    assign w_acc_bit   = w_wait_pad[cmd.cmd_idx];
    assign w_op        = op_t'(cmd.cmd_op);
    assign w_accept    = (r_state == S_IDLE) && r_ready && cmd.cmd_valid;
    assign w_dur       = cmd.cmd_data[CNT_W-1:0];
    assign w_idx_bad   = ((w_op == OP_SET)     && ({1'b0, cmd.cmd_idx} >= SET_LIM)) ||
                         ((w_op == OP_WAIT_EV) && ({1'b0, cmd.cmd_idx} >= WAIT_LIM));
    assign w_limit_hit = (r_cnt == r_limit - CNT_W'(1));

    always_comb begin
        w_event = 1'b0;
        case (r_kind)
            2'd0:    w_event = ~r_prev &  w_cur;
            2'd1:    w_event =  r_prev & ~w_cur;
            2'd2:    w_event =  w_cur;
            default: w_event = ~w_cur;
        endcase
    end

    // Completion decision for the current cycle; abort outranks event, event outranks timeout.
    always_comb begin
        w_fin         = 1'b0;
        w_fin_status  = RS_OK;
        w_fin_elapsed = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_idx_bad) begin
                        w_fin        = 1'b1;
                        w_fin_status = RS_BAD_IDX;
                    end else if ((w_op == OP_NOP) || ((w_op == OP_WAIT_DUR) && (w_dur == '0))) begin
                        w_fin = 1'b1;
                    end
                end
            end
            S_SET: w_fin = 1'b1;
            S_WAIT_EV: begin
                w_fin_elapsed = r_cnt;
                if (abort) begin
                    w_fin        = 1'b1;
                    w_fin_status = RS_ABORTED;
                end else if (w_event) begin
                    w_fin = 1'b1;
                end else if ((r_limit != '0) && w_limit_hit) begin
                    w_fin        = 1'b1;
                    w_fin_status = RS_TIMEOUT;
                end
            end
            S_WAIT_DUR: begin
                w_fin_elapsed = r_cnt;
                if (abort) begin
                    w_fin        = 1'b1;
                    w_fin_status = RS_ABORTED;
                end else if (w_limit_hit) begin
                    w_fin = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_ready       <= 1'b1;
            r_set_en      <= 1'b0;
            r_set_idx     <= '0;
            r_set_value   <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_status  <= RS_OK;
            r_rsp_elapsed <= '0;
            r_cnt         <= '0;
            r_limit       <= '0;
            r_prev        <= 1'b0;
            r_idx         <= '0;
            r_kind        <= '0;
        end else begin
            r_set_en    <= 1'b0;
            r_rsp_valid <= 1'b0;
            if (w_fin) begin
                r_state       <= S_RESP;
                r_rsp_valid   <= 1'b1;
                r_rsp_status  <= w_fin_status;
                r_rsp_elapsed <= w_fin_elapsed;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_ready <= 1'b0;
                        r_cnt   <= '0;
                        r_prev  <= w_acc_bit;
                        r_idx   <= cmd.cmd_idx;
                        r_kind  <= cmd.cmd_data[1:0];
                        r_limit <= (w_op == OP_WAIT_DUR) ? w_dur : cmd.cmd_timeout;
                        if (!w_fin) begin
                            case (w_op)
                                OP_SET: begin
                                    r_state     <= S_SET;
                                    r_set_en    <= 1'b1;
                                    r_set_idx   <= cmd.cmd_idx;
                                    r_set_value <= cmd.cmd_data;
                                end
                                OP_WAIT_EV:  r_state <= S_WAIT_EV;
                                OP_WAIT_DUR: r_state <= S_WAIT_DUR;
                                default: ;
                            endcase
                        end
                    end
                end
                S_WAIT_EV: begin
                    r_prev <= w_cur;
                    if (!w_fin) r_cnt <= r_cnt + CNT_W'(1);
                end
                S_WAIT_DUR: begin
                    if (!w_fin) r_cnt <= r_cnt + CNT_W'(1);
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign cmd.cmd_ready   = r_ready;
    assign cmd.rsp_valid   = r_rsp_valid;
    assign cmd.rsp_status  = r_rsp_status;
    assign cmd.rsp_elapsed = r_rsp_elapsed;
    assign set_en          = r_set_en;
    assign set_idx         = r_set_idx;
    assign set_value       = r_set_value;
endmodule

// File: tb/tb_tb_cmd_dispatcher.sv
// Bench for tb_cmd_dispatcher: directed vector table, reset/hold sequences, and
// random commands scored against a cycle-offset outcome model.
module tb_tb_cmd_dispatcher;
    localparam int TL      = 48;
    localparam int LAT_MAX = 64;
    localparam logic [1:0] OP_SET = 2'd0, OP_WEV = 2'd1, OP_WDUR = 2'd2, OP_NOP = 2'd3;
    localparam logic [1:0] ST_OK = 2'd0, ST_TMO = 2'd1, ST_BAD = 2'd2, ST_ABT = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        abort = 1'b0;
    logic [4:0]  wait_signals = '0;
    logic        set_en;
    logic [2:0]  set_idx;
    logic [31:0] set_value;

    tb_cmd_dispatcher_if #(.SET_WIDTH(32), .IDX_W(3), .CNT_W(16)) u_if ();

    tb_cmd_dispatcher #(
        .SET_SIZE(5), .SET_WIDTH(32), .WAIT_SIZE(5), .IDX_W(3), .CNT_W(16)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .cmd(u_if),
        .abort(abort),
        .wait_signals(wait_signals),
        .set_en(set_en),
        .set_idx(set_idx),
        .set_value(set_value)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  idx;
        logic [31:0] data;
        logic [15:0] tmo;
        logic        bef;
        logic        aft;
        int          ev_at;
        int          ab_at;
        int          lat;
        logic [1:0]  st;
        logic [15:0] el;
        bit          set;
    } vec_t;

    vec_t        tbl [15];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [4:0]  sig [TL];
    logic        ab  [TL];
    logic [1:0]  last_st = '0;
    logic [15:0] last_el = '0;
    logic [2:0]  last_set_idx = '0;
    logic [31:0] last_set_val = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"},   64'(u_if.cmd_ready), 64'd1);
        chk({tag, "_set_en"},  64'(set_en), 64'd0);
        chk({tag, "_set_idx"}, 64'(set_idx), 64'd0);
        chk({tag, "_set_val"}, 64'(set_value), 64'd0);
        chk({tag, "_rsp_v"},   64'(u_if.rsp_valid), 64'd0);
        chk({tag, "_rsp_st"},  64'(u_if.rsp_status), 64'd0);
        chk({tag, "_rsp_el"},  64'(u_if.rsp_elapsed), 64'd0);
    endtask

    task automatic build_trace(input logic [2:0] idx, input logic bef, input logic aft,
                               input int ev_at, input int ab_at);
        for (int k = 0; k < TL; k++) begin
            sig[k] = '0;
            if (idx < 3'd5) sig[k][idx] = (k < ev_at) ? bef : aft;
            ab[k] = (ab_at != 0) && (k == ab_at);
        end
    endtask

    // Outcome as a function of cycle offset k after accept (k=0 is the accept cycle).
    task automatic model(input logic [1:0] op, input logic [2:0] idx, input logic [31:0] data,
                         input logic [15:0] tmo, output int lat, output logic [1:0] st,
                         output logic [15:0] el, output bit set, output bit ok);
        int d;
        bit cur, prev, hit;
        lat = 1; st = ST_OK; el = '0; set = 1'b0; ok = 1'b1;
        case (op)
            OP_SET: begin
                if (idx >= 3'd5) st = ST_BAD;
                else begin set = 1'b1; lat = 2; end
            end
            OP_NOP: ;
            OP_WDUR: begin
                d = int'(data[15:0]);
                if (d > 0) begin
                    lat = d + 1;
                    el  = 16'(d - 1);
                    for (int k = 1; k <= d; k++) begin
                        if (ab[k]) begin st = ST_ABT; el = 16'(k - 1); lat = k + 1; break; end
                    end
                end
            end
            default: begin
                if (idx >= 3'd5) st = ST_BAD;
                else begin
                    ok = 1'b0;
                    for (int k = 1; k < TL && !ok; k++) begin
                        prev = sig[k-1][idx];
                        cur  = sig[k][idx];
                        case (data[1:0])
                            2'd0:    hit = !prev && cur;
                            2'd1:    hit = prev && !cur;
                            2'd2:    hit = cur;
                            default: hit = !cur;
                        endcase
                        if (ab[k])                            begin ok = 1'b1; st = ST_ABT; end
                        else if (hit)                         begin ok = 1'b1; st = ST_OK;  end
                        else if (tmo != 0 && k == int'(tmo))  begin ok = 1'b1; st = ST_TMO; end
                        if (ok) begin lat = k + 1; el = 16'(k - 1); end
                    end
                end
            end
        endcase
    endtask

    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [2:0] idx,
                           input logic [31:0] data, input logic [15:0] tmo, input int exp_lat,
                           input logic [1:0] exp_st, input logic [15:0] exp_el, input bit exp_set);
        int          got = -1;
        int          set_cnt = 0;
        int          set_k = -1;
        logic [2:0]  s_idx = '0;
        logic [31:0] s_val = '0;
        logic [1:0]  g_st = '0;
        logic [15:0] g_el = '0;
        @(negedge clk);
        chk({tag, "_ready"}, 64'(u_if.cmd_ready), 64'd1);
        chk({tag, "_idle_rsp"}, 64'(u_if.rsp_valid), 64'd0);
        u_if.cmd_valid   = 1'b1;
        u_if.cmd_op      = op;
        u_if.cmd_idx     = idx;
        u_if.cmd_data    = data;
        u_if.cmd_timeout = tmo;
        wait_signals     = sig[0];
        abort            = ab[0];
        for (int k = 1; k <= LAT_MAX; k++) begin
            @(negedge clk);
            u_if.cmd_valid = 1'b0;
            if (set_en) begin set_cnt++; set_k = k; s_idx = set_idx; s_val = set_value; end
            if (u_if.rsp_valid) begin
                got  = k;
                g_st = u_if.rsp_status;
                g_el = u_if.rsp_elapsed;
                break;
            end
            if (k < TL) begin
                wait_signals = sig[k];
                abort        = ab[k];
            end
        end
        abort = 1'b0;
        chk({tag, "_latency"}, 64'(got), 64'(exp_lat));
        chk({tag, "_status"},  64'(g_st), 64'(exp_st));
        chk({tag, "_elapsed"}, 64'(g_el), 64'(exp_el));
        chk({tag, "_set_cnt"}, 64'(set_cnt), exp_set ? 64'd1 : 64'd0);
        if (exp_set) begin
            chk({tag, "_set_cyc"}, 64'(set_k), 64'd1);
            chk({tag, "_set_idx"}, 64'(s_idx), 64'(idx));
            chk({tag, "_set_val"}, 64'(s_val), 64'(data));
            last_set_idx = idx;
            last_set_val = data;
        end
        last_st = exp_st;
        last_el = exp_el;
    endtask

    task automatic chk_hold(input string tag);
        repeat (3) @(negedge clk);
        chk({tag, "_hold_st"},  64'(u_if.rsp_status), 64'(last_st));
        chk({tag, "_hold_el"},  64'(u_if.rsp_elapsed), 64'(last_el));
        chk({tag, "_hold_idx"}, 64'(set_idx), 64'(last_set_idx));
        chk({tag, "_hold_val"}, 64'(set_value), 64'(last_set_val));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  r_op;
        logic [2:0]  r_idx;
        logic [31:0] r_data;
        logic [15:0] r_tmo;
        int          m_lat;
        logic [1:0]  m_st;
        logic [15:0] m_el;
        bit          m_set, m_ok;
        int          act, seen;

        u_if.cmd_valid   = 1'b0;
        u_if.cmd_op      = '0;
        u_if.cmd_idx     = '0;
        u_if.cmd_data    = '0;
        u_if.cmd_timeout = '0;

        //         op       idx    data            tmo     bef   aft   ev  ab  lat st      el      set
        tbl[0]  = '{OP_SET,  3'd2, 32'hCAFEDECA, 16'd0,  1'b0, 1'b0, 99, 0,  2, ST_OK,  16'd0, 1'b1};
        tbl[1]  = '{OP_WEV,  3'd0, 32'd0,        16'd0,  1'b0, 1'b1, 6,  0,  7, ST_OK,  16'd5, 1'b0};
        tbl[2]  = '{OP_WEV,  3'd1, 32'd2,        16'd10, 1'b0, 1'b0, 99, 0, 11, ST_TMO, 16'd9, 1'b0};
        tbl[3]  = '{OP_WDUR, 3'd0, 32'd0,        16'd0,  1'b0, 1'b0, 99, 0,  1, ST_OK,  16'd0, 1'b0};
        tbl[4]  = '{OP_WDUR, 3'd0, 32'd4,        16'd0,  1'b0, 1'b0, 99, 0,  5, ST_OK,  16'd3, 1'b0};
        tbl[5]  = '{OP_WDUR, 3'd0, 32'd4,        16'd0,  1'b0, 1'b0, 99, 3,  4, ST_ABT, 16'd2, 1'b0};
        tbl[6]  = '{OP_SET,  3'd7, 32'h12345678, 16'd0,  1'b0, 1'b0, 99, 0,  1, ST_BAD, 16'd0, 1'b0};
        tbl[7]  = '{OP_WEV,  3'd5, 32'd2,        16'd0,  1'b0, 1'b0, 99, 0,  1, ST_BAD, 16'd0, 1'b0};
        tbl[8]  = '{OP_WEV,  3'd3, 32'd0,        16'd0,  1'b0, 1'b1, 4,  4,  5, ST_ABT, 16'd3, 1'b0};
        tbl[9]  = '{OP_WEV,  3'd4, 32'd2,        16'd5,  1'b0, 1'b1, 5,  0,  6, ST_OK,  16'd4, 1'b0};
        tbl[10] = '{OP_NOP,  3'd6, 32'hFFFFFFFF, 16'd3,  1'b0, 1'b0, 99, 0,  1, ST_OK,  16'd0, 1'b0};
        tbl[11] = '{OP_WEV,  3'd2, 32'd1,        16'd0,  1'b1, 1'b0, 3,  0,  4, ST_OK,  16'd2, 1'b0};
        tbl[12] = '{OP_WEV,  3'd0, 32'd3,        16'd0,  1'b0, 1'b0, 99, 0,  2, ST_OK,  16'd0, 1'b0};
        tbl[13] = '{OP_WEV,  3'd1, 32'd0,        16'd3,  1'b1, 1'b1, 0,  0,  4, ST_TMO, 16'd2, 1'b0};
        tbl[14] = '{OP_WDUR, 3'd7, 32'hFFFF0001, 16'd0,  1'b0, 1'b0, 99, 0,  2, ST_OK,  16'd0, 1'b0};

        repeat (2) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            build_trace(tbl[i].idx, tbl[i].bef, tbl[i].aft, tbl[i].ev_at, tbl[i].ab_at);
            run_cmd($sformatf("vec%0d", i), tbl[i].op, tbl[i].idx, tbl[i].data, tbl[i].tmo,
                    tbl[i].lat, tbl[i].st, tbl[i].el, tbl[i].set);
        end
        chk_hold("vec");

        // Reset while a forever-wait is in progress drops the command silently.
        build_trace(3'd0, 1'b0, 1'b0, 99, 0);
        @(negedge clk);
        u_if.cmd_valid   = 1'b1;
        u_if.cmd_op      = OP_WEV;
        u_if.cmd_idx     = 3'd0;
        u_if.cmd_data    = 32'd2;
        u_if.cmd_timeout = 16'd0;
        wait_signals     = '0;
        @(negedge clk);
        u_if.cmd_valid = 1'b0;
        chk("midwait_busy", 64'(u_if.cmd_ready), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset("midrst");
        rst = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (u_if.rsp_valid) seen++;
        end
        chk("midrst_no_rsp", 64'(seen), 64'd0);
        last_st = '0; last_el = '0; last_set_idx = '0; last_set_val = '0;
        build_trace(3'd0, 1'b0, 1'b0, 99, 0);
        run_cmd("post_rst_nop", OP_NOP, 3'd0, 32'd0, 16'd0, 1, ST_OK, 16'd0, 1'b0);

        for (int n = 0; n < 200; n++) begin
            r_op   = 2'($urandom_range(0, 3));
            r_idx  = 3'($urandom_range(0, 7));
            r_data = $urandom;
            r_tmo  = 16'($urandom_range(0, 15));
            if (r_op == OP_WDUR) r_data[15:0] = 16'($urandom_range(0, 12));
            act    = int'($urandom_range(0, 3));
            sig[0] = 5'($urandom);
            ab[0]  = 1'($urandom_range(0, 1));
            for (int k = 1; k < TL; k++) begin
                sig[k] = (act == 0) ? sig[k-1] : 5'($urandom);
                ab[k]  = ($urandom_range(0, 19) == 0);
            end
            model(r_op, r_idx, r_data, r_tmo, m_lat, m_st, m_el, m_set, m_ok);
            if (!m_ok) begin
                r_tmo = 16'd20;
                model(r_op, r_idx, r_data, r_tmo, m_lat, m_st, m_el, m_set, m_ok);
            end
            run_cmd($sformatf("rnd%0d", n), r_op, r_idx, r_data, r_tmo, m_lat, m_st, m_el, m_set);
        end
        chk_hold("rnd");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
